// File: rtl/sce_cap_pkg.sv
// Shared constants and the MISR step used by the output-capture block.
package sce_cap_pkg;

  localparam int OUT_W_DEF  = 10;
  localparam int DEPTH_DEF  = 8;
  localparam int MISR_MAX_W = 32;

  // x^10 + x^3 + 1
  localparam logic [OUT_W_DEF-1:0] POLY = 10'h009;

  // One MISR step on a w-bit register carried in a MISR_MAX_W-bit container.
  function automatic logic [MISR_MAX_W-1:0] misr_step(
    input logic [MISR_MAX_W-1:0] sig,
    input logic [MISR_MAX_W-1:0] data,
    input logic [MISR_MAX_W-1:0] poly,
    input int                    w
  );
    logic [MISR_MAX_W-1:0] mask;
    logic [MISR_MAX_W-1:0] shifted;
    logic                  msb;
    mask    = (w >= MISR_MAX_W) ? '1 : ((MISR_MAX_W'(1) << w) - MISR_MAX_W'(1));
    msb     = |(sig & (MISR_MAX_W'(1) << (w - 1)));
    shifted = sig << 1;
    if (msb) shifted = shifted ^ poly;
    return (shifted ^ data) & mask;
  endfunction

endpackage

// File: rtl/sce_sync_fifo.sv
// Small synchronous FIFO; count/full/empty/dout come straight from registered state.
module sce_sync_fifo #(
  parameter int W     = 10,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               din,
  output logic [W-1:0]               dout,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign dout  = mem[rd_ptr];

  // A push on full only lands when the head leaves in the same cycle.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sce_output_capture.sv
// Captures results of a fixed-latency pipelined netlist into a FIFO, with
// credit-based launch throttling and a MISR signature over pushed results.
module sce_output_capture
  import sce_cap_pkg::*;
#(
  parameter int               OUT_W      = OUT_W_DEF,
  parameter int               DEPTH      = DEPTH_DEF,
  parameter int               FIFO_DEPTH = 4,
  parameter logic [OUT_W-1:0] POLY       = sce_cap_pkg::POLY
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             launch_valid,
  output logic             launch_ready,
  input  logic [OUT_W-1:0] y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  input  logic             clear,
  output logic [OUT_W-1:0] signature,
  output logic             overflow,
  output logic [7:0]       drop_count
);

  localparam int CNT_W = $clog2(FIFO_DEPTH+1);

  logic [DEPTH-1:0] vpipe;
  logic [CNT_W-1:0] fifo_cnt;
  logic             fifo_full;
  logic             fifo_empty;
  logic             cap;
  logic             pop;
  logic             push_ok;
  logic             drop;

  // vpipe is not touched by clear: in-flight vectors still emerge afterwards.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vpipe <= '0;
    end else begin
      vpipe[0] <= launch_valid;
      for (int i = 1; i < DEPTH; i++) vpipe[i] <= vpipe[i-1];
    end
  end

  assign cap = vpipe[DEPTH-1];

  // Credits count both in-flight vectors and buffered results; out_ready is
  // deliberately excluded so launch_ready depends on registered state only.
  always_comb begin
    launch_ready = ($countones(vpipe) + int'(fifo_cnt)) < FIFO_DEPTH;
  end

  // Output handshake: a result transfers on any cycle with out_valid and
  // out_ready both high; out_data holds while out_valid && !out_ready.
  assign out_valid = ~fifo_empty;
  assign pop       = out_valid & out_ready;
  assign push_ok   = cap & ~clear & (~fifo_full | pop);
  assign drop      = cap & ~clear & fifo_full & ~pop;

  sce_sync_fifo #(
    .W     (OUT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (clear),
    .push  (cap & ~clear),
    .pop   (pop),
    .din   (y),
    .dout  (out_data),
    .count (fifo_cnt),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      signature  <= '0;
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (clear) begin
      signature  <= '0;
      overflow   <= 1'b0;
      drop_count <= '0;
    end else begin
      if (push_ok)
        signature <= OUT_W'(misr_step(MISR_MAX_W'(signature), MISR_MAX_W'(y),
                                      MISR_MAX_W'(POLY), OUT_W));
      if (drop) begin
        overflow <= 1'b1;
        if (drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_sce_output_capture.sv
// Bench for sce_output_capture: a behavioural netlist delay line feeds y, a
// scoreboard checks every transfer, and directed sequences cover credits/clear.
module tb_sce_output_capture;

  localparam int W     = 10;
  localparam int DEPTH = 8;

  logic         clk          = 1'b0;
  logic         rst_n        = 1'b0;
  logic         launch_valid = 1'b0;
  logic         out_ready    = 1'b0;
  logic         clear        = 1'b0;
  logic [W-1:0] launch_data  = '0;
  logic [W-1:0] y;
  logic         launch_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic [W-1:0] signature;
  logic         overflow;
  logic [7:0]   drop_count;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  typedef struct {
    logic [W-1:0] y_val;
    logic [W-1:0] exp_sig;
  } vec_t;
  vec_t tbl[6];

  always #5 clk = ~clk;

  sce_output_capture dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .launch_valid (launch_valid),
    .launch_ready (launch_ready),
    .y            (y),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .clear        (clear),
    .signature    (signature),
    .overflow     (overflow),
    .drop_count   (drop_count)
  );

  // Stand-in for the netlist: data launched now appears on y DEPTH cycles later;
  // random junk otherwise so mistimed captures are visible.
  logic [W-1:0]     nl_d [DEPTH] = '{default: '0};
  logic [DEPTH-1:0] nl_v = '0;
  logic [W-1:0]     junk = '0;

  always @(posedge clk) begin
    nl_v    <= {nl_v[DEPTH-2:0], launch_valid};
    nl_d[0] <= launch_data;
    for (int i = 1; i < DEPTH; i++) nl_d[i] <= nl_d[i-1];
    junk    <= W'($urandom_range(0, 1023));
  end

  assign y = nl_v[DEPTH-1] ? nl_d[DEPTH-1] : junk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every accepted transfer must match the oldest expected result.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got %0h expected nothing", out_data);
      end else begin
        check("scoreboard_data", 32'(out_data), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [W-1:0] d, input bit kept);
    launch_valid = 1'b1;
    launch_data  = d;
    if (kept) exp_q.push_back(d);
    tick();
    launch_valid = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    out_ready = 1'b0;
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
    end
    check("drain_empty", 32'(out_valid), 32'd0);
  endtask

  function automatic logic [W-1:0] misr_ref(input logic [W-1:0] s, input logic [W-1:0] d);
    logic [W-1:0] r;
    r = {s[W-2:0], 1'b0};
    if (s[W-1]) r = r ^ 10'h009;
    return r ^ d;
  endfunction

  initial begin
    logic [W-1:0] ov[6];
    logic [W-1:0] g, p, q, r, s_exp;
    int n_launch;

    tbl[0] = '{10'h001, 10'h001};
    tbl[1] = '{10'h200, 10'h202};
    tbl[2] = '{10'h000, 10'h00D};
    tbl[3] = '{10'h3FF, 10'h3E5};
    tbl[4] = '{10'h155, 10'h296};
    tbl[5] = '{10'h0AA, 10'h18F};

    // Reset with launch_valid held high: nothing may be captured later.
    launch_valid = 1'b1;
    launch_data  = 10'h155;
    tick();
    tick();
    check("rst_launch_ready", 32'(launch_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_signature", 32'(signature), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_drop_count", 32'(drop_count), 32'd0);
    rst_n        = 1'b1;
    launch_valid = 1'b0;
    out_ready    = 1'b1;
    repeat (DEPTH + 3) begin
      tick();
      check("rst_no_capture", 32'(out_valid), 32'd0);
    end
    out_ready = 1'b0;

    // Latency: result visible exactly DEPTH+1 edges after launch.
    launch(10'h2A5, 1'b1);
    repeat (DEPTH - 1) tick();
    check("latency_early", 32'(out_valid), 32'd0);
    tick();
    check("latency_valid", 32'(out_valid), 32'd1);
    check("latency_data", 32'(out_data), 32'h2A5);
    check("latency_sig", 32'(signature), 32'h2A5);
    tick();
    check("hold_data", 32'(out_data), 32'h2A5);
    drain();

    // MISR table, one capture at a time from a cleared signature.
    pulse_clear();
    check("misr_clear", 32'(signature), 32'd0);
    for (int i = 0; i < 6; i++) begin
      launch(tbl[i].y_val, 1'b1);
      repeat (DEPTH) tick();
      check("misr_valid", 32'(out_valid), 32'd1);
      check("misr_data", 32'(out_data), 32'(tbl[i].y_val));
      check("misr_sig", 32'(signature), 32'(tbl[i].exp_sig));
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("misr_popped", 32'(out_valid), 32'd0);
    end

    // Credit throttle with a stalled consumer.
    n_launch = 0;
    repeat (DEPTH + 4) begin
      if (launch_ready) begin
        launch(W'($urandom_range(0, 1023)), 1'b1);
        n_launch++;
      end else begin
        tick();
      end
    end
    repeat (DEPTH) tick();
    check("credit_launches", 32'(n_launch), 32'd4);
    check("credit_ready_low", 32'(launch_ready), 32'd0);
    check("credit_fifo_valid", 32'(out_valid), 32'd1);
    check("credit_no_overflow", 32'(overflow), 32'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("credit_reassert", 32'(launch_ready), 32'd1);
    drain();

    // Forced overflow: six launches into a four-entry FIFO.
    pulse_clear();
    for (int i = 0; i < 6; i++) begin
      ov[i] = W'($urandom_range(0, 1023));
      launch(ov[i], i < 4);
    end
    repeat (DEPTH + 2) tick();
    s_exp = '0;
    for (int i = 0; i < 4; i++) s_exp = misr_ref(s_exp, ov[i]);
    check("ovf_flag", 32'(overflow), 32'd1);
    check("ovf_drop_count", 32'(drop_count), 32'd2);
    check("ovf_ready_low", 32'(launch_ready), 32'd0);
    check("ovf_head", 32'(out_data), 32'(ov[0]));
    check("ovf_sig", 32'(signature), 32'(s_exp));

    // Push on full with a simultaneous pop must not drop.
    g = W'($urandom_range(0, 1023));
    launch(g, 1'b1);
    repeat (DEPTH - 1) tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    s_exp = misr_ref(s_exp, g);
    check("fullpop_drop_count", 32'(drop_count), 32'd2);
    check("fullpop_sig", 32'(signature), 32'(s_exp));
    check("fullpop_head", 32'(out_data), 32'(ov[1]));

    // Clear mid-flight: p coincides with clear and is lost; q and r survive.
    p = W'($urandom_range(0, 1023));
    q = W'($urandom_range(0, 1023));
    r = W'($urandom_range(0, 1023));
    launch(p, 1'b0);
    launch(q, 1'b0);
    launch(r, 1'b0);
    repeat (DEPTH - 3) tick();
    pulse_clear();
    exp_q.delete();
    exp_q.push_back(q);
    exp_q.push_back(r);
    check("clr_out_valid", 32'(out_valid), 32'd0);
    check("clr_signature", 32'(signature), 32'd0);
    check("clr_overflow", 32'(overflow), 32'd0);
    check("clr_drop_count", 32'(drop_count), 32'd0);
    tick();
    check("clr_q_valid", 32'(out_valid), 32'd1);
    check("clr_q_data", 32'(out_data), 32'(q));
    check("clr_q_sig", 32'(signature), 32'(misr_ref('0, q)));
    tick();
    check("clr_r_sig", 32'(signature), 32'(misr_ref(misr_ref('0, q), r)));
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sce_output_capture.md
Name: sce_output_capture

Overview:
- Downstream consumer of a path-balanced, fully pipelined benchmark netlist with 7 inputs x0..x6, 10 outputs y0..y9 and a fixed logic depth in clock stages.
- Tracks each launched input vector through the netlist depth and samples the outputs exactly when that vector's result emerges.
- Buffers results in a small FIFO with a ready/valid output and a credit-based launch throttle.
- Folds every captured result into a MISR signature for regression comparison.

Parameters:
- OUT_W, 10, result width (y0..y9 packed, y0 = bit 0).
- DEPTH, 8, netlist latency in clock cycles from launch to valid outputs; legal range 1..32.
- FIFO_DEPTH, 4, result FIFO entries; power of two, at least 2.
- POLY, 10'h009, MISR feedback taps (x^10 + x^3 + 1).

Ports:
- clk  in  1  single clock.
- rst_n  in  1  synchronous active-low reset.
- launch_valid  in  1  an input vector enters the netlist this cycle.
- launch_ready  out  1  credit available; the source must launch only when this is high.
- y  in  OUT_W  netlist outputs, combinationally valid every cycle.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer accepts the head.
- out_data  out  OUT_W  FIFO head.
- clear  in  1  synchronous flush of FIFO, signature and flags.
- signature  out  OUT_W  MISR state.
- overflow  out  1  sticky: a capture was dropped.
- drop_count  out  8  saturating count of dropped captures.

Behaviour:
- Reset and clock: one clock, clk. Reset is synchronous and active-low on rst_n; all state updates on the rising edge of clk.
- Reset values: all state zero. launch_ready=1, out_valid=0, out_data=0, signature=0, overflow=0, drop_count=0.
- Valid tracking:
  - A DEPTH-bit shift register vpipe; vpipe[0] <= launch_valid.
  - cap = vpipe[DEPTH-1]. When cap=1, the current y is the result of the vector launched DEPTH cycles earlier.
  - Launch in cycle t → cap in cycle t+DEPTH → out_valid in cycle t+DEPTH+1 if the FIFO was empty.
- Credits:
  - inflight = popcount(vpipe); fifo_cnt in 0..FIFO_DEPTH.
  - launch_ready = (inflight + fifo_cnt) < FIFO_DEPTH. This is combinational from registered state only, with no dependence on out_ready.
  - launch_valid while launch_ready=0 is accepted into vpipe anyway (the netlist cannot stall). It may later cause a drop.
- FIFO:
  - push = cap; pop = out_valid & out_ready.
  - Push on full with simultaneous pop: both occur, no drop.
  - Push on full without pop: data discarded, overflow <= 1, drop_count increments and saturates at 255.
  - Pop on empty: impossible because out_valid=0.
  - Pointers wrap modulo FIFO_DEPTH. out_data holds the head and is stable while out_valid & !out_ready.
- MISR:
  - Updates only on a cap that is actually pushed; dropped data is not folded.
  - Update: sig_next = {sig[OUT_W-2:0],1'b0} ^ (sig[OUT_W-1] ? POLY : 0) ^ y.
- clear:
  - Empties the FIFO and zeroes signature, overflow and drop_count.
  - Does not clear vpipe: in-flight results still arrive and are captured after the clear cycle.
  - A cap in the same cycle as clear is discarded; clear has priority.
- rst_n low mid-operation: all state, including vpipe, zeroed next edge; in-flight results are lost.

Decomposition:
- Shared package sce_cap_pkg:
  - OUT_W default and DEPTH default.
  - POLY constant.
  - misr_step function: (sig, data) → sig.
- One sub-module: sce_sync_fifo, parameterised by width and depth.
  - Ports: push, pop, din, dout, count, full, empty, flush.
  - Outputs are registered state only.
- Valid pipeline, credit logic and MISR stay in the top.

Test Plan:
1. Reset: hold rst_n=0 for 2 cycles with launch_valid=1 → launch_ready=1, out_valid=0, signature=0; no capture appears DEPTH cycles after release.
2. Latency: DEPTH=8, single launch at cycle 10, y=10'h2A5 during cycle 18 → out_valid rises at cycle 19 with out_data=10'h2A5; signature=10'h2A5.
3. Credit throttle: out_ready=0, launch every cycle while launch_ready=1 → exactly 4 launches accepted, then launch_ready=0. The FIFO fills to 4, overflow stays 0, and draining one entry reasserts launch_ready the next cycle.
4. Forced overflow: out_ready=0, 6 launches ignoring launch_ready → 4 entries held, overflow=1, drop_count=2, and signature folds only the 4 pushed values. Push on full with simultaneous pop → no drop.
5. MISR: captures 10'h001 then 10'h200 from zero → signature 10'h001, then 10'h202. A third capture 10'h000 → 10'h40D masked to OUT_W, i.e. 10'h00D (the shifted MSB feeds POLY).
6. Clear mid-flight: 3 results in flight, assert clear for 1 cycle → FIFO empty, signature=0, overflow=0. Results arriving after the clear cycle are captured; a cap coincident with clear is discarded.
